// File: rtl/alsu.sv
// Registered 3-bit arithmetic/logic/shift unit: one input register stage,
// then a registered 6-bit result and a 16-bit blink-on-error LED bank.
module alsu #(
  parameter INPUT_PRIORITY = "A",
  parameter FULL_ADDER     = "ON"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] A,
  input  logic [2:0] B,
  input  logic [2:0] opcode,
  input  logic       cin,
  input  logic       serial_in,
  input  logic       direction,
  input  logic       red_op_A,
  input  logic       red_op_B,
  input  logic       bypass_A,
  input  logic       bypass_B,
  output logic [5:0] out,
  output logic [15:0] leds
);

  localparam logic PRIO_A  = (INPUT_PRIORITY == "A");
  localparam logic USE_CIN = (FULL_ADDER == "ON");

  logic [2:0]  a_q, b_q, opcode_q;
  logic        cin_q, serial_in_q, direction_q;
  logic        red_op_a_q, red_op_b_q, bypass_a_q, bypass_b_q;
  logic [5:0]  out_q, out_d;
  logic [15:0] leds_q, leds_d;

  logic        invalid;
  logic        red_use_a;
  logic [2:0]  red_operand;
  logic [5:0]  sum;
  logic [5:0]  product;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      opcode_q    <= '0;
      cin_q       <= 1'b0;
      serial_in_q <= 1'b0;
      direction_q <= 1'b0;
      red_op_a_q  <= 1'b0;
      red_op_b_q  <= 1'b0;
      bypass_a_q  <= 1'b0;
      bypass_b_q  <= 1'b0;
      out_q       <= '0;
      leds_q      <= '0;
    end else begin
      a_q         <= A;
      b_q         <= B;
      opcode_q    <= opcode;
      cin_q       <= cin;
      serial_in_q <= serial_in;
      direction_q <= direction;
      red_op_a_q  <= red_op_A;
      red_op_b_q  <= red_op_B;
      bypass_a_q  <= bypass_A;
      bypass_b_q  <= bypass_B;
      out_q       <= out_d;
      leds_q      <= leds_d;
    end
  end

  // Reduction flags are only meaningful for the AND/XOR opcodes (000, 001).
  assign invalid = (opcode_q[2:1] == 2'b11) ||
                   ((red_op_a_q || red_op_b_q) && (opcode_q[2:1] != 2'b00));

  assign red_use_a   = red_op_a_q && (!red_op_b_q || PRIO_A);
  assign red_operand = red_use_a ? a_q : b_q;
  assign sum         = {3'b000, a_q} + {3'b000, b_q} + {5'b00000, cin_q & USE_CIN};
  assign product     = {3'b000, a_q} * {3'b000, b_q};

  always_comb begin
    out_d  = out_q;
    leds_d = invalid ? ~leds_q : 16'h0000;
    if (bypass_a_q && bypass_b_q) begin
      out_d = {3'b000, PRIO_A ? a_q : b_q};
    end else if (bypass_a_q) begin
      out_d = {3'b000, a_q};
    end else if (bypass_b_q) begin
      out_d = {3'b000, b_q};
    end else if (invalid) begin
      out_d = '0;
    end else begin
      case (opcode_q)
        3'b000: out_d = (red_op_a_q || red_op_b_q) ? {5'b00000, &red_operand}
                                                    : {3'b000, a_q & b_q};
        3'b001: out_d = (red_op_a_q || red_op_b_q) ? {5'b00000, ^red_operand}
                                                    : {3'b000, a_q ^ b_q};
        3'b010: out_d = sum;
        3'b011: out_d = product;
        // Shift and rotate step the result register itself, one bit per cycle.
        3'b100: out_d = direction_q ? {out_q[4:0], serial_in_q}
                                    : {serial_in_q, out_q[5:1]};
        3'b101: out_d = direction_q ? {out_q[4:0], out_q[5]}
                                    : {out_q[0], out_q[5:1]};
        default: out_d = '0;
      endcase
    end
  end

  assign out  = out_q;
  assign leds = leds_q;

endmodule

// File: tb/tb_alsu.sv
// Directed bench for alsu: two instances (priority A / full adder, and
// priority B / plain adder) share stimulus and are checked against hand values.
module tb_alsu;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] A, B, opcode;
  logic       cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
  logic [5:0] out_a, out_b;
  logic [15:0] leds_a, leds_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alsu #(.INPUT_PRIORITY("A"), .FULL_ADDER("ON")) dut_a (
    .clk(clk), .rst(rst), .A(A), .B(B), .opcode(opcode), .cin(cin),
    .serial_in(serial_in), .direction(direction), .red_op_A(red_op_A),
    .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out(out_a), .leds(leds_a)
  );

  alsu #(.INPUT_PRIORITY("B"), .FULL_ADDER("OFF")) dut_b (
    .clk(clk), .rst(rst), .A(A), .B(B), .opcode(opcode), .cin(cin),
    .serial_in(serial_in), .direction(direction), .red_op_A(red_op_A),
    .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out(out_b), .leds(leds_b)
  );

  typedef struct {
    string      name;
    logic [2:0] a, b, op;
    logic       cin, ser, dir, ra, rb, ba, bb;
    logic [5:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [5:0] ea, input logic [5:0] eb,
                         input logic [15:0] el);
    chk({name, " out_a"}, {10'd0, out_a}, {10'd0, ea});
    chk({name, " out_b"}, {10'd0, out_b}, {10'd0, eb});
    chk({name, " leds_a"}, leds_a, el);
    chk({name, " leds_b"}, leds_b, el);
    $display("%0t %s: out_a=%0d out_b=%0d leds=%h", $time, name, out_a, out_b, leds_a);
  endtask

  task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                       input logic ci, input logic ser, input logic dir,
                       input logic ra, input logic rb, input logic ba, input logic bb);
    A = a; B = b; opcode = op; cin = ci; serial_in = ser; direction = dir;
    red_op_A = ra; red_op_B = rb; bypass_A = ba; bypass_B = bb;
  endtask

  task automatic idle();
    drive(3'd0, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic two_edges();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    //           name          a     b     op      cin   ser   dir   ra    rb    ba    bb    exp_a  exp_b
    vecs[0]  = '{"byp_A",      3'd5, 3'd2, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd5,  6'd5};
    vecs[1]  = '{"byp_both",   3'd3, 3'd6, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd3,  6'd6};
    vecs[2]  = '{"byp_B",      3'd1, 3'd4, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd4,  6'd4};
    vecs[3]  = '{"redA_and",   3'd7, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1,  6'd1};
    vecs[4]  = '{"redA_xor",   3'd3, 3'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0};
    vecs[5]  = '{"red2_and",   3'd6, 3'd7, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  6'd1};
    vecs[6]  = '{"red2_xor",   3'd7, 3'd3, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1,  6'd0};
    vecs[7]  = '{"redB_xor",   3'd0, 3'd4, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1,  6'd1};
    vecs[8]  = '{"and",        3'd6, 3'd3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2,  6'd2};
    vecs[9]  = '{"xor",        3'd5, 3'd3, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd6,  6'd6};
    vecs[10] = '{"add_max",    3'd7, 3'd7, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd15, 6'd14};
    vecs[11] = '{"add",        3'd2, 3'd3, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd5,  6'd5};
    vecs[12] = '{"mul_max",    3'd7, 3'd7, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd49, 6'd49};
    vecs[13] = '{"mul",        3'd3, 3'd5, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd15, 6'd15};
    vecs[14] = '{"add_cin",    3'd0, 3'd0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1,  6'd0};

    rst = 1'b1;
    idle();

    // Reset held with random inputs.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk);
      #1;
      chk_all("reset", 6'd0, 6'd0, 16'h0000);
    end

    @(negedge clk);
    rst = 1'b0;
    idle();
    two_edges();
    chk_all("reset_release", 6'd0, 6'd0, 16'h0000);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin, vecs[i].ser, vecs[i].dir,
            vecs[i].ra, vecs[i].rb, vecs[i].ba, vecs[i].bb);
      two_edges();
      chk_all(vecs[i].name, vecs[i].exp_a, vecs[i].exp_b, 16'h0000);
    end

    // Bypass overrides an invalid opcode, but the LEDs still blink.
    @(negedge clk);
    drive(3'd5, 3'd1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    two_edges();
    chk_all("byp_op111", 6'd5, 6'd5, 16'hFFFF);
    @(posedge clk); #1;
    chk_all("byp_op111_blink", 6'd5, 6'd5, 16'h0000);
    @(negedge clk);
    idle();
    two_edges();
    chk_all("byp_exit", 6'd0, 6'd0, 16'h0000);

    // Opcode 110: zero result and alternating LEDs.
    @(negedge clk);
    drive(3'd7, 3'd7, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    two_edges();
    chk_all("inv110_0", 6'd0, 6'd0, 16'hFFFF);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk_all($sformatf("inv110_%0d", k), 6'd0, 6'd0, (k % 2) ? 16'h0000 : 16'hFFFF);
    end
    @(negedge clk);
    drive(3'd6, 3'd3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    two_edges();
    chk_all("inv110_exit", 6'd2, 6'd2, 16'h0000);

    // Reduction flag with an arithmetic opcode is invalid; reset during blink.
    @(negedge clk);
    drive(3'd7, 3'd7, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    two_edges();
    chk_all("redB_op011_0", 6'd0, 6'd0, 16'hFFFF);
    @(posedge clk); #1;
    chk_all("redB_op011_1", 6'd0, 6'd0, 16'h0000);
    @(posedge clk); #1;
    chk_all("redB_op011_2", 6'd0, 6'd0, 16'hFFFF);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all("rst_mid_blink", 6'd0, 6'd0, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    idle();
    two_edges();
    chk_all("after_blink_rst", 6'd0, 6'd0, 16'h0000);

    // Build 100101 from 3*3=9, then shift left with fills 0 and 1.
    @(negedge clk);
    drive(3'd3, 3'd3, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    two_edges();
    chk_all("preload_mul", 6'd9, 6'd9, 16'h0000);
    @(negedge clk);
    drive(3'd0, 3'd0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    drive(3'd0, 3'd0, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("shl_s0_a", 6'b010010, 6'b010010, 16'h0000);
    @(negedge clk);
    drive(3'd0, 3'd0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("shl_s1", 6'b100101, 6'b100101, 16'h0000);
    @(negedge clk);
    drive(3'd0, 3'd0, 3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("shl_s0_b", 6'b001010, 6'b001010, 16'h0000);
    @(negedge clk);
    drive(3'd0, 3'd0, 3'b101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("rot_right", 6'b000101, 6'b000101, 16'h0000);
    @(negedge clk);
    drive(3'd0, 3'd0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("rot_left", 6'b001010, 6'b001010, 16'h0000);
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    chk_all("shr_s1", 6'b100101, 6'b100101, 16'h0000);

    // Reset arriving mid-shift.
    @(negedge clk);
    drive(3'd0, 3'd0, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    two_edges();
    chk_all("shl_after_and", 6'b000001, 6'b000001, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all("rst_mid_shift", 6'd0, 6'd0, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    idle();
    two_edges();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alsu.md
# alsu

Registered 3-bit arithmetic/logic/shift unit (ALSU) that returns a 6-bit result. Operations: AND, XOR, reduction, add, multiply, shift and rotate, plus bypass of either operand. Every input is captured in an input register, and the result and the LED error indicator are registered. Latency from input to output is two clock edges. It is a standalone datapath block driven by a host controller, with its `leds` output wired to a status LED bank.

## Interface
- `INPUT_PRIORITY`, default `"A"`: selects which operand wins when both bypass flags, or both reduction flags, are set. Legal values are `"A"` and `"B"`.
- `FULL_ADDER`, default `"ON"`: `"ON"` means addition includes `cin`; `"OFF"` means addition ignores `cin`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `A` in 3: operand A, unsigned.
- `B` in 3: operand B, unsigned.
- `opcode` in 3: operation select.
- `cin` in 1: carry-in, used only when `FULL_ADDER = "ON"`.
- `serial_in` in 1: fill bit for shift operations.
- `direction` in 1: 1 = left, 0 = right, for shift and rotate.
- `red_op_A` in 1: use the reduction of A for opcodes 000 and 001.
- `red_op_B` in 1: use the reduction of B for opcodes 000 and 001.
- `bypass_A` in 1: drive A to `out`.
- `bypass_B` in 1: drive B to `out`.
- `out` out 6: registered result.
- `leds` out 16: registered error indicator.

## Operation
- **Input stage.** All inputs except `clk` and `rst` are registered every cycle. These are `A`, `B`, `opcode`, `cin`, `serial_in`, `direction`, the two `red_op` flags and the two `bypass` flags. All later decisions use the registered copies.
- **Invalid condition.** Invalid is true when either:
  - the registered opcode is 110 or 111, or
  - `red_op_A` or `red_op_B` is set and the opcode is not 000 or 001.
- **Output priority**, highest first:
  1. **Bypass.** If `bypass_A` and `bypass_B` are both set, the `INPUT_PRIORITY` operand is used. Otherwise the single set flag decides. `out = {3'b0, operand}`.
  2. **Invalid.** `out = 0`.
  3. **Opcode:**
     - **000:** If a `red_op` flag is set, `out = {5'b0, &X}`, where X is A or B. If both flags are set, X follows `INPUT_PRIORITY`. Otherwise `out = {3'b0, A & B}`.
     - **001:** Same as 000 but XOR: `^X` or `A ^ B`.
     - **010:** `out = A + B + cin` when `FULL_ADDER = "ON"`, otherwise `A + B`. The maximum is 15, so no overflow.
     - **011:** `out = A * B`. The maximum is 49, so no overflow.
     - **100 (shift of the current `out`):**
       - left: `{out[4:0], serial_in}`
       - right: `{serial_in, out[5:1]}`
     - **101 (rotate of the current `out`):**
       - left: `{out[4:0], out[5]}`
       - right: `{out[0], out[5:1]}`
- **LEDs.**
  - When invalid holds, `leds <= ~leds`, so all 16 bits blink, toggling every cycle. This happens even when bypass is overriding `out`.
  - When invalid does not hold, `leds <= 0`.

## Timing
- **Reset.** On a rising edge with `rst = 1`:
  - all input registers clear to 0;
  - `out` clears to 0;
  - `leds` clears to 0.
- Reset overrides every other condition, including mid-shift and mid-blink.
- **Latency.** Inputs present at edge N are registered at N. The corresponding `out` and `leds` update at edge N+1. Opcodes 000–011 and bypass therefore give results two edges after the host drives them, counting from the negedge drive.
- **Shift and rotate.** These operate on the `out` register's own previous value, one step per cycle while the opcode is held. They compose across consecutive cycles.
- **Leaving invalid.** When invalid deasserts, `leds` returns to 0 on the next output edge.
- **Reset release.** After `rst` deasserts, the first valid result appears two edges later. The register contents after reset give `out = 0` (AND of zeros).

## Test plan
- **Reset.** Hold `rst = 1` for 20 cycles with random inputs → `out = 0` and `leds = 0` every cycle.
- **Bypass.**
  - `bypass_A = 1`, `A = 5` → `out = 5`, two edges later, for any opcode including 111.
  - `bypass_A = bypass_B = 1`, `A = 3`, `B = 6`, `INPUT_PRIORITY = "A"` → `out = 3`.
  - Same stimulus with `INPUT_PRIORITY = "B"` → `out = 6`.
- **Reduction.**
  - `red_op_A = 1`, opcode 000, `A = 7` → `out = 1`.
  - Opcode 001, `A = 3` → `out = 0`.
  - Both flags set, priority `"A"`, `A = 6`, `B = 7`, opcode 000 → `out = 0`.
- **Invalid.**
  - Opcode 110 with no bypass → `out = 0`, and `leds` alternates `16'hFFFF`, `16'h0000`, … every cycle.
  - `red_op_B = 1` with opcode 011 → same behaviour.
  - Return to opcode 000 → `leds = 0`.
- **Arithmetic.**
  - Opcode 010, `A = 7`, `B = 7`, `cin = 1` → `out = 15` with `FULL_ADDER = "ON"`, or `out = 14` with `"OFF"`.
  - Opcode 011, `A = 7`, `B = 7` → `out = 49`.
- **Shift and rotate.**
  - Preload `out = 6'b100101` via multiply/add. Then:
    - opcode 100, left, `serial_in = 0` → `001010`;
    - next cycle, opcode 101, right → `000101`;
    - next cycle, opcode 101, left → `001010`.
